// File: rtl/pdi_decoder_pkg.sv
// Shared types and field positions for the PDI word decoder.
// Instruction opcodes and segment-header bit positions are kept here so every stage agrees on them.
package pdi_decoder_pkg;

  localparam int PDI_W = 32;
  localparam int LEN_W = 16;

  // Opcode and header bit positions within a PDI word.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int DTYPE_MSB = 31;
  localparam int DTYPE_LSB = 28;
  localparam int EOI_BIT   = 26;
  localparam int EOT_BIT   = 25;
  localparam int LAST_BIT  = 24;
  localparam int LEN_MSB   = 15;

  localparam logic [3:0] OP_ENC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_LDKEY  = 4'b0100;
  localparam logic [3:0] OP_LDSEED = 4'b1000;

  typedef enum logic [1:0] {
    S_INSTR = 2'd0,
    S_HEAD  = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  typedef struct packed {
    logic              instr_vld;
    logic              head_vld;
    logic              data_vld;
    logic              decrypt;
    logic              key_update;
    logic              key_only;
    logic              seed_update;
    logic [3:0]        dtype;
    logic              eoi;
    logic              eot;
    logic              last;
    logic [LEN_W-1:0]  length;
    logic              seg_empty;
    logic [3:0]        sel_nibble;
    logic [PDI_W-1:0]  data;
    logic              partial;
    logic              last_of_seg;
  } item_t;

  // Byte-lane mask of the final word; byte0 sits in bits [31:24] and maps to mask bit 3.
  function automatic logic [3:0] sel_nibble_f(input logic [LEN_W-1:0] len);
    logic [3:0] mask;
    if (len == '0) begin
      mask = 4'b0000;
    end else begin
      case (len[1:0])
        2'b00:   mask = 4'b1111;
        2'b01:   mask = 4'b1000;
        2'b10:   mask = 4'b1100;
        default: mask = 4'b1110;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/pdi_decoder_if.sv
// Bundle of the PDI input handshake and the decoder-to-controller item/fetch signals.
// The decoder uses the slave view; the source/controller side uses the master view.
interface pdi_decoder_if;
  import pdi_decoder_pkg::*;

  logic [PDI_W-1:0] pdi_data;
  logic             pdi_valid;
  logic             pdi_ready;

  logic             instruction_valid;
  logic             header_valid;
  logic             data_in_valid;
  logic             rdy_instr_fetch;
  logic             rdy_head_fetch;
  logic             rdy_data_fetch;

  logic             decrypt;
  logic             key_update;
  logic             key_only;
  logic             seed_update;
  logic [3:0]       dtype;
  logic             eoi;
  logic             eot;
  logic             last;
  logic [LEN_W-1:0] length;
  logic             seg_empty;
  logic [3:0]       sel_nibble;
  logic [PDI_W-1:0] data_out;
  logic             data_in_partial;
  logic             data_in_last_of_seg;
  logic             opcode_err;

  modport slave (
    input  pdi_data, pdi_valid, rdy_instr_fetch, rdy_head_fetch, rdy_data_fetch,
    output pdi_ready, instruction_valid, header_valid, data_in_valid,
           decrypt, key_update, key_only, seed_update, dtype, eoi, eot, last,
           length, seg_empty, sel_nibble, data_out, data_in_partial,
           data_in_last_of_seg, opcode_err
  );

  modport master (
    output pdi_data, pdi_valid, rdy_instr_fetch, rdy_head_fetch, rdy_data_fetch,
    input  pdi_ready, instruction_valid, header_valid, data_in_valid,
           decrypt, key_update, key_only, seed_update, dtype, eoi, eot, last,
           length, seg_empty, sel_nibble, data_out, data_in_partial,
           data_in_last_of_seg, opcode_err
  );

endinterface

// File: rtl/pdi_decoder.sv
// Splits the PDI word stream into instruction, segment-header and data items, holding one
// registered item at a time until the controller fetches it; tracks remaining segment bytes.
module pdi_decoder
  import pdi_decoder_pkg::*;
#(
  parameter int BUS_SIZE = PDI_W
) (
  input  logic         clk,
  input  logic         rst,
  pdi_decoder_if.slave bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              seg_last_q, seg_last_d;
  item_t             item_q, item_d;
  logic              opcode_err_q, opcode_err_d;

  logic [BUS_SIZE-1:0] word;
  logic [3:0]          opc;
  logic [LEN_W-1:0]    hdr_len;
  logic                any_valid;
  logic                taken;
  logic                accept;
  logic                unused_hdr;

  assign word    = bus.pdi_data;
  assign opc     = word[OPC_MSB:OPC_LSB];
  assign hdr_len = word[LEN_MSB:0];
  // Header bit 27 and bits [23:16] are reserved and carry nothing for the controller.
  assign unused_hdr = ^{word[27], word[23:16]};

  assign any_valid = item_q.instr_vld | item_q.head_vld | item_q.data_vld;
  assign taken     = (item_q.instr_vld & bus.rdy_instr_fetch)
                   | (item_q.head_vld  & bus.rdy_head_fetch)
                   | (item_q.data_vld  & bus.rdy_data_fetch);
  // Releasing the held item frees the register for a new word in the same cycle.
  assign bus.pdi_ready = ~any_valid | taken;
  assign accept        = bus.pdi_valid & bus.pdi_ready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    seg_last_d   = seg_last_q;
    item_d       = item_q;
    opcode_err_d = 1'b0;

    if (taken) begin
      item_d.instr_vld = 1'b0;
      item_d.head_vld  = 1'b0;
      item_d.data_vld  = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        S_INSTR: begin
          if (opc == OP_ENC || opc == OP_DEC || opc == OP_LDKEY || opc == OP_LDSEED) begin
            item_d.instr_vld   = 1'b1;
            item_d.decrypt     = (opc == OP_DEC);
            item_d.key_update  = (opc == OP_LDKEY);
            item_d.key_only    = (opc == OP_LDKEY) || (opc == OP_LDSEED);
            item_d.seed_update = (opc == OP_LDSEED);
            state_d            = S_HEAD;
          end else begin
            opcode_err_d = 1'b1;
          end
        end

        S_HEAD: begin
          item_d.head_vld   = 1'b1;
          item_d.dtype      = word[DTYPE_MSB:DTYPE_LSB];
          item_d.eoi        = word[EOI_BIT];
          item_d.eot        = word[EOT_BIT];
          item_d.last       = word[LAST_BIT];
          item_d.length     = hdr_len;
          item_d.seg_empty  = (hdr_len == '0);
          item_d.sel_nibble = sel_nibble_f(hdr_len);
          seg_last_d        = word[LAST_BIT];
          if (hdr_len != '0) begin
            rem_d   = hdr_len;
            state_d = S_DATA;
          end else if (word[LAST_BIT]) begin
            state_d = S_INSTR;
          end
        end

        S_DATA: begin
          item_d.data_vld    = 1'b1;
          item_d.data        = word;
          item_d.partial     = (rem_q < LEN_W'(4));
          item_d.last_of_seg = (rem_q <= LEN_W'(4));
          // Saturating countdown: the final word may carry fewer than four bytes.
          rem_d = (rem_q > LEN_W'(4)) ? rem_q - LEN_W'(4) : '0;
          if (rem_q <= LEN_W'(4)) begin
            state_d = seg_last_q ? S_INSTR : S_HEAD;
          end
        end

        default: state_d = S_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INSTR;
      rem_q        <= '0;
      seg_last_q   <= 1'b0;
      item_q       <= '0;
      opcode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      seg_last_q   <= seg_last_d;
      item_q       <= item_d;
      opcode_err_q <= opcode_err_d;
    end
  end

  assign bus.instruction_valid   = item_q.instr_vld;
  assign bus.header_valid        = item_q.head_vld;
  assign bus.data_in_valid       = item_q.data_vld;
  assign bus.decrypt             = item_q.decrypt;
  assign bus.key_update          = item_q.key_update;
  assign bus.key_only            = item_q.key_only;
  assign bus.seed_update         = item_q.seed_update;
  assign bus.dtype               = item_q.dtype;
  assign bus.eoi                 = item_q.eoi;
  assign bus.eot                 = item_q.eot;
  assign bus.last                = item_q.last;
  assign bus.length              = item_q.length;
  assign bus.seg_empty           = item_q.seg_empty;
  assign bus.sel_nibble          = item_q.sel_nibble;
  assign bus.data_out            = item_q.data;
  assign bus.data_in_partial     = item_q.partial;
  assign bus.data_in_last_of_seg = item_q.last_of_seg;
  assign bus.opcode_err          = opcode_err_q;

endmodule

// File: tb/tb_pdi_decoder.sv
// Scoreboard bench for pdi_decoder: messages are generated at item level, the expected
// item sequence is queued alongside the words, and a monitor checks every fetched item.
`timescale 1ns/1ps
module tb_pdi_decoder;
  import pdi_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdi_decoder_if bus();

  pdi_decoder #(.BUS_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] stim_q[$];
  logic [63:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  logic [31:0] first_data;

  localparam logic [70:0] RST_OUTS = {5'b00001, 66'b0};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [63:0] act);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected item %h, nothing outstanding", name, act);
    end else begin
      check(name, 80'(act), 80'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [70:0] outs();
    return {bus.instruction_valid, bus.header_valid, bus.data_in_valid, bus.opcode_err,
            bus.pdi_ready, bus.decrypt, bus.key_update, bus.key_only, bus.seed_update,
            bus.dtype, bus.eoi, bus.eot, bus.last, bus.length, bus.seg_empty,
            bus.sel_nibble, bus.data_out, bus.data_in_partial, bus.data_in_last_of_seg};
  endfunction

  // Reference model: an instruction word yields one item (or an error pulse); a segment
  // yields a header item plus ceil(len/4) data items, the last one partial if len%4 != 0.
  task automatic add_instr(input logic [3:0] op);
    logic [3:0] f;
    stim_q.push_back({op, 28'($urandom)});
    case (op)
      4'h2:    f = 4'b0000;
      4'h3:    f = 4'b1000;
      4'h4:    f = 4'b0110;
      4'h8:    f = 4'b0011;
      default: f = 4'bxxxx;
    endcase
    if (op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'h8)
      exp_q.push_back({2'd0, 58'b0, f});
    else
      exp_q.push_back({2'd3, 62'b0});
  endtask

  task automatic add_seg(input logic [3:0] dtype, input logic eoi, input logic eot,
                         input logic last, input logic [15:0] len);
    int         tail, nw;
    logic [3:0] sel;
    logic [31:0] d;
    stim_q.push_back({dtype, 1'($urandom), eoi, eot, last, 8'($urandom), len});
    tail = int'(len) % 4;
    nw   = (int'(len) + 3) / 4;
    if (len == 16'd0)   sel = 4'b0000;
    else if (tail == 0) sel = 4'b1111;
    else if (tail == 1) sel = 4'b1000;
    else if (tail == 2) sel = 4'b1100;
    else                sel = 4'b1110;
    exp_q.push_back({2'd1, 34'b0, dtype, eoi, eot, last, len, (len == 16'd0), sel});
    for (int k = 0; k < nw; k++) begin
      d = $urandom;
      if (k == 0) first_data = d;
      stim_q.push_back(d);
      exp_q.push_back({2'd2, 28'b0, d, (k == nw - 1) && (tail != 0), (k == nw - 1)});
    end
  endtask

  task automatic add_msg();
    logic [3:0] op;
    int         r, nseg;
    logic [15:0] len;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      do op = 4'($urandom); while (op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'h8);
      add_instr(op);
    end else begin
      case ($urandom_range(0, 3))
        0:       op = 4'h2;
        1:       op = 4'h3;
        2:       op = 4'h4;
        default: op = 4'h8;
      endcase
      add_instr(op);
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
        len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        add_seg(4'($urandom), 1'($urandom), 1'($urandom), (s == nseg - 1), len);
      end
    end
  endtask

  // One handshake cycle; inputs are already driven just after the previous rising edge.
  task automatic step_hs();
    logic acc;
    @(negedge clk);
    acc = bus.pdi_valid && bus.pdi_ready;
    @(posedge clk);
    #1;
    if (acc && stim_q.size() > 0) begin
      stim_q.delete(0);
      n_acc++;
    end
  endtask

  task automatic run_stream(input int stall, input int budget);
    int   cyc;
    logic acc;
    cyc = 0;
    while (stim_q.size() > 0 && cyc < budget) begin
      bus.pdi_valid       = ($urandom_range(0, 99) >= stall);
      bus.pdi_data        = stim_q[0];
      bus.rdy_instr_fetch = ($urandom_range(0, 99) >= stall);
      bus.rdy_head_fetch  = ($urandom_range(0, 99) >= stall);
      bus.rdy_data_fetch  = ($urandom_range(0, 99) >= stall);
      @(negedge clk);
      acc = bus.pdi_valid && bus.pdi_ready;
      if (stall == 0) check("ready_no_stall", 80'(bus.pdi_ready), 80'd1);
      @(posedge clk);
      #1;
      if (acc) stim_q.delete(0);
      cyc++;
    end
    n_tests++;
    if (stim_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout: %0d words left, required 0", stim_q.size());
      stim_q.delete();
    end
    bus.pdi_valid       = 1'b0;
    bus.rdy_instr_fetch = 1'b1;
    bus.rdy_head_fetch  = 1'b1;
    bus.rdy_data_fetch  = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every fetch handshake and every error pulse consumes one expected item.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.instruction_valid || bus.header_valid || bus.data_in_valid)
        check("onehot_valid",
              80'($countones({bus.instruction_valid, bus.header_valid, bus.data_in_valid}) == 1),
              80'd1);
      if (bus.opcode_err)
        pop_cmp("opcode_err", {2'd3, 62'b0});
      if (bus.instruction_valid && bus.rdy_instr_fetch)
        pop_cmp("instr_item", {2'd0, 58'b0, bus.decrypt, bus.key_update, bus.key_only,
                               bus.seed_update});
      if (bus.header_valid && bus.rdy_head_fetch)
        pop_cmp("header_item", {2'd1, 34'b0, bus.dtype, bus.eoi, bus.eot, bus.last,
                                bus.length, bus.seg_empty, bus.sel_nibble});
      if (bus.data_in_valid && bus.rdy_data_fetch)
        pop_cmp("data_item", {2'd2, 28'b0, bus.data_out, bus.data_in_partial,
                              bus.data_in_last_of_seg});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.pdi_valid       = 1'b0;
    bus.pdi_data        = '0;
    bus.rdy_instr_fetch = 1'b1;
    bus.rdy_head_fetch  = 1'b1;
    bus.rdy_data_fetch  = 1'b1;
    rst = 1'b0;
    #2;
    check("reset_outs", 80'(outs()), 80'(RST_OUTS));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ENC, two-word segment, then an empty last segment with everything ready.
    add_instr(4'h2);
    add_seg(4'h1, 1'b0, 1'b0, 1'b0, 16'd8);
    add_seg(4'h5, 1'b0, 1'b0, 1'b1, 16'd0);
    run_stream(0, 200);

    // Odd length, bad opcode recovery, LDKEY with a 16-byte segment.
    add_instr(4'h2);
    add_seg(4'h3, 1'b1, 1'b1, 1'b1, 16'd5);
    add_instr(4'hF);
    add_instr(4'h3);
    add_seg(4'h2, 1'b0, 1'b0, 1'b1, 16'd0);
    add_instr(4'h4);
    add_seg(4'h4, 1'b0, 1'b0, 1'b1, 16'd16);
    run_stream(25, 400);

    repeat (60) add_msg();
    run_stream(30, 20000);

    // Backpressure: hold the first data item for five cycles.
    add_instr(4'h2);
    add_seg(4'h1, 1'b0, 1'b0, 1'b1, 16'd8);
    bus.rdy_data_fetch = 1'b0;
    guard = 0;
    while (!bus.data_in_valid && guard < 10) begin
      bus.pdi_valid = 1'b1;
      bus.pdi_data  = stim_q[0];
      step_hs();
      guard++;
    end
    check("bp_reach_data", 80'(bus.data_in_valid), 80'd1);
    bus.pdi_data = stim_q[0];
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 80'(bus.data_in_valid), 80'd1);
      check("bp_data_held", 80'(bus.data_out), 80'(first_data));
      check("bp_ready_low", 80'(bus.pdi_ready), 80'd0);
      @(posedge clk);
      #1;
    end
    bus.rdy_data_fetch = 1'b1;
    @(negedge clk);
    check("bp_same_cycle_accept", 80'(bus.pdi_ready && bus.pdi_valid), 80'd1);
    @(posedge clk);
    #1;
    stim_q.delete(0);
    run_stream(0, 20);

    // Asynchronous reset in the middle of a segment with 12 bytes still to come.
    add_instr(4'h2);
    add_seg(4'h1, 1'b0, 1'b0, 1'b1, 16'd20);
    n_acc = 0;
    guard = 0;
    while (n_acc < 4 && guard < 20) begin
      bus.pdi_valid = 1'b1;
      bus.pdi_data  = stim_q[0];
      step_hs();
      guard++;
    end
    check("mid_seg_words", 80'(n_acc), 80'd4);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outs", 80'(outs()), 80'(RST_OUTS));
    stim_q.delete();
    exp_q.delete();
    bus.pdi_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    add_instr(4'h3);
    add_seg(4'h7, 1'b0, 1'b1, 1'b1, 16'd3);
    run_stream(0, 50);

    // Maximum length segment: 16384 words, final one carrying three bytes.
    add_instr(4'h8);
    add_seg(4'h9, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    run_stream(0, 17000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
